ecc_scrub_ctrl: RTL and testbench
=================================

ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 Parameter AW, default 8: memory address width (depth 2^AW words).
REQ-002 Parameter INTERVAL, default 1024: idle cycles between scrub words, at least 2.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 scrub_en  in  1  enables scrubbing.
REQ-006 usr_req  in  1  functional access owns the memory port this cycle.
REQ-007 usr_we  in  1  the functional access is a write.
REQ-008 usr_addr  in  AW  functional access address.
REQ-009 mem_re / mem_we  out  1 each  scrubber read and write strobes.
REQ-010 mem_addr  out  AW;  mem_wdata  out  64;  mem_rdata  in  64, valid the cycle after mem_re. Word layout: [63:57] parity, [56:0] data.
REQ-011 dec_data  out  57;  dec_parity  out  7;  dec_bypass  out  1: drive the external SECDED decoder.
REQ-012 dec_cdata  in  57;  dec_cparity  in  7;  dec_sbit  in  1;  dec_dbit  in  1: decoder corrected data, recomputed parity and error flags, all combinational from the dec_* outputs.
REQ-013 sbit_cnt / dbit_cnt  out  16 each: error counters.
REQ-014 dbit_irq  out  1  one-cycle pulse;  dbit_addr  out  AW  address of the last double-bit error;  pass_done  out  1  one-cycle pulse.

Function
REQ-015 Use states IDLE, RD, CAP, CHK, ENC, WR, NEXT.
REQ-016 IDLE: the interval counter increments while scrub_en=1 and holds at 0 while scrub_en=0. When the count reaches INTERVAL-1, the counter clears and the FSM moves to RD.
REQ-017 RD: if usr_req=1, wait with mem_re=0. Otherwise assert mem_re=1 with mem_addr=scrub_addr for one cycle and go to CAP.
REQ-018 CAP: register mem_rdata, then go to CHK.
REQ-019 CHK: drive the registered word with dec_bypass=0.
- No error: go to NEXT.
- dec_sbit=1: latch dec_cdata, increment sbit_cnt, go to ENC. This includes parity-only errors, where the data is unchanged.
- dec_dbit=1: increment dbit_cnt, pulse dbit_irq, latch dbit_addr=scrub_addr, go to NEXT with no writeback.
REQ-020 ENC: drive the corrected data, capture dec_cparity as the new parity, go to WR.
REQ-021 WR: if usr_req=1, wait. Otherwise assert mem_we=1 for one cycle with mem_wdata={parity,data} and go to NEXT.
REQ-022 NEXT: increment scrub_addr. On wrap from 2^AW-1 to 0, pulse pass_done. Go to IDLE.
REQ-023 dec_bypass=1 in every state except CHK and ENC.
REQ-024 mem_re and mem_we are 0 whenever usr_req=1; the scrubber never blocks a functional access.
REQ-025 If usr_req=1, usr_we=1 and usr_addr=scrub_addr in any of CAP, CHK, ENC or WR, cancel the writeback and go to NEXT. An sbit_cnt increment that has already occurred stands.
REQ-026 If scrub_en falls mid-word, the current word completes through NEXT and the FSM then holds in IDLE.
REQ-027 Counters saturate at 16'hFFFF.
REQ-028 sbit_cnt and dbit_cnt update in the cycle after the CHK decision.

Reset
REQ-029 On rst=1 at a clock edge:
- FSM goes to IDLE; interval counter and scrub_addr go to 0.
- mem_re, mem_we, dbit_irq and pass_done go to 0.
- sbit_cnt, dbit_cnt, dbit_addr, mem_addr and mem_wdata go to 0.
- dec_bypass goes to 1.
REQ-030 Reset asserted mid-operation abandons any pending write; no partial write is ever issued.

Configuration
REQ-031 Macro ECC_SCRUB_CNT_EN. When defined, sbit_cnt and dbit_cnt are implemented as specified. When undefined, both are tied to 0 and no counter flops exist; dbit_irq and dbit_addr are unaffected.

Structure
REQ-032 Shared package ecc_scrub_pkg holds:
- the state enum;
- DATA_W=57, PAR_W=7, WORD_W=64, CNT_W=16.
REQ-033 One sub-module, ecc_scrub_timer, implements the interval counter and its expiry pulse.
REQ-034 The decoder is external; this block contains no ECC logic.

Verification
All scenarios use AW=4, INTERVAL=4 and a bench-side behavioural SECDED decoder.
REQ-035 All 16 words clean, scrub_en=1 -> 16 reads, addresses 0..15 in order, zero writes, pass_done exactly once after address 15, sbit_cnt=0.
REQ-036 Word 3 data bit 10 flipped -> exactly one mem_we at address 3 with the original correct 64-bit word; sbit_cnt=1.
REQ-037 Word 5 with data bits 0 and 1 flipped -> no write; dbit_irq high for 1 cycle; dbit_addr=5; dbit_cnt=1.
REQ-038 usr_req held high for 10 cycles while in RD -> mem_re=0 throughout; mem_re=1 on the first cycle after usr_req drops.
REQ-039 User write to address 3 while in ENC for address 3 -> no scrubber mem_we; next read is at address 4; sbit_cnt=1.
REQ-040 rst pulsed while in WR with usr_req=1 -> no mem_we ever issued; the next cycle shows IDLE, counters 0 and scrub_addr 0.

Source files
------------

// File: rtl/ecc_scrub_pkg.sv
// Shared types and widths for the ECC scrub controller.
// Word layout is {parity[6:0], data[56:0]}.
package ecc_scrub_pkg;

  localparam int unsigned DATA_W = 57;
  localparam int unsigned PAR_W  = 7;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    CHK  = 3'd3,
    ENC  = 3'd4,
    WR   = 3'd5,
    NEXT = 3'd6
  } scrub_state_e;

  typedef struct packed {
    logic [PAR_W-1:0]  parity;
    logic [DATA_W-1:0] data;
  } ecc_word_t;

  // Saturating increment for the error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// Memory-port and external-decoder signals of the scrub controller.
// master = scrubber side, slave = memory/decoder side.
interface ecc_scrub_ctrl_if #(
  parameter int unsigned AW = 8
);

  logic                              mem_re;
  logic                              mem_we;
  logic [AW-1:0]                     mem_addr;
  logic [ecc_scrub_pkg::WORD_W-1:0]  mem_wdata;
  logic [ecc_scrub_pkg::WORD_W-1:0]  mem_rdata;

  logic [ecc_scrub_pkg::DATA_W-1:0]  dec_data;
  logic [ecc_scrub_pkg::PAR_W-1:0]   dec_parity;
  logic                              dec_bypass;
  logic [ecc_scrub_pkg::DATA_W-1:0]  dec_cdata;
  logic [ecc_scrub_pkg::PAR_W-1:0]   dec_cparity;
  logic                              dec_sbit;
  logic                              dec_dbit;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wdata,
    output dec_data, dec_parity, dec_bypass,
    input  mem_rdata,
    input  dec_cdata, dec_cparity, dec_sbit, dec_dbit
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wdata,
    input  dec_data, dec_parity, dec_bypass,
    output mem_rdata,
    output dec_cdata, dec_cparity, dec_sbit, dec_dbit
  );

endinterface

// File: rtl/ecc_scrub_timer.sv
// Idle-interval counter: counts while enabled, clears when disabled,
// and flags the final cycle of each INTERVAL-long window.
module ecc_scrub_timer #(
  parameter int unsigned INTERVAL = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned TW = $clog2(INTERVAL);

  logic [TW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == TW'(INTERVAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_expire_c = i_en && w_last;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: walks memory, corrects single-bit errors via an
// external SECDED decoder, reports double-bit errors. Macro ECC_SCRUB_CNT_EN enables the error counters.
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned INTERVAL = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_scrub_en,
  input  logic                i_usr_req,
  input  logic                i_usr_we,
  input  logic [AW-1:0]       i_usr_addr,
  ecc_scrub_ctrl_if.master    bus,
  output logic [CNT_W-1:0]    o_sbit_cnt,
  output logic [CNT_W-1:0]    o_dbit_cnt,
  output logic                o_dbit_irq,
  output logic [AW-1:0]       o_dbit_addr,
  output logic                o_pass_done
);

  scrub_state_e        r_state;
  logic [AW-1:0]       r_scrub_addr;
  logic [AW-1:0]       r_dbit_addr;
  logic [DATA_W-1:0]   r_data;
  logic [PAR_W-1:0]    r_par;
  logic                r_dec_bypass;
  logic                r_dbit_irq;
  logic                r_pass_done;

  logic                w_idle_en;
  logic                w_expire_c;
  logic                w_clash;
  ecc_word_t           w_rd_word;

  assign w_idle_en = (r_state == IDLE) && i_scrub_en;

  ecc_scrub_timer #(
    .INTERVAL (INTERVAL)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_idle_en),
    .o_expire_c (w_expire_c)
  );

  // A functional write to the word in flight makes our copy stale.
  assign w_clash   = i_usr_req && i_usr_we && (i_usr_addr == r_scrub_addr);
  assign w_rd_word = ecc_word_t'(bus.mem_rdata);

  // Strobes are gated by usr_req in the same cycle so the user port always wins.
  assign bus.mem_re     = !rst && !i_usr_req && (r_state == RD);
  assign bus.mem_we     = !rst && !i_usr_req && (r_state == WR);
  assign bus.mem_addr   = r_scrub_addr;
  assign bus.mem_wdata  = WORD_W'({r_par, r_data});
  assign bus.dec_data   = r_data;
  assign bus.dec_parity = r_par;
  assign bus.dec_bypass = r_dec_bypass;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_scrub_addr <= '0;
      r_data       <= '0;
      r_par        <= '0;
      r_dec_bypass <= 1'b1;
      r_dbit_irq   <= 1'b0;
      r_dbit_addr  <= '0;
      r_pass_done  <= 1'b0;
    end else begin
      r_dbit_irq  <= 1'b0;
      r_pass_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_expire_c) r_state <= RD;
        end
        RD: begin
          if (!i_usr_req) r_state <= CAP;
        end
        CAP: begin
          if (w_clash) begin
            r_state <= NEXT;
          end else begin
            r_data       <= w_rd_word.data;
            r_par        <= w_rd_word.parity;
            r_dec_bypass <= 1'b0;
            r_state      <= CHK;
          end
        end
        // Error accounting happens regardless of a clash; only the writeback is dropped.
        CHK: begin
          r_dec_bypass <= 1'b1;
          r_state      <= NEXT;
          if (bus.dec_sbit) begin
            r_data <= bus.dec_cdata;
            if (!w_clash) begin
              r_dec_bypass <= 1'b0;
              r_state      <= ENC;
            end
          end else if (bus.dec_dbit) begin
            r_dbit_irq  <= 1'b1;
            r_dbit_addr <= r_scrub_addr;
          end
        end
        ENC: begin
          r_dec_bypass <= 1'b1;
          if (w_clash) begin
            r_state <= NEXT;
          end else begin
            r_par   <= bus.dec_cparity;
            r_state <= WR;
          end
        end
        WR: begin
          if (w_clash || !i_usr_req) r_state <= NEXT;
        end
        NEXT: begin
          r_scrub_addr <= r_scrub_addr + AW'(1);
          r_pass_done  <= &r_scrub_addr;
          r_state      <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_dec_bypass <= 1'b1;
        end
      endcase
    end
  end

  assign o_dbit_irq  = r_dbit_irq;
  assign o_dbit_addr = r_dbit_addr;
  assign o_pass_done = r_pass_done;

`ifdef ECC_SCRUB_CNT_EN
  logic [CNT_W-1:0] r_sbit_cnt;
  logic [CNT_W-1:0] r_dbit_cnt;
  logic             w_chk_sbit;
  logic             w_chk_dbit;

  assign w_chk_sbit = (r_state == CHK) && bus.dec_sbit;
  assign w_chk_dbit = (r_state == CHK) && !bus.dec_sbit && bus.dec_dbit;

  // Counters register the CHK decision, so they move one cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sbit_cnt <= '0;
      r_dbit_cnt <= '0;
    end else begin
      if (w_chk_sbit) r_sbit_cnt <= sat_inc(r_sbit_cnt);
      if (w_chk_dbit) r_dbit_cnt <= sat_inc(r_dbit_cnt);
    end
  end

  assign o_sbit_cnt = r_sbit_cnt;
  assign o_dbit_cnt = r_dbit_cnt;
`else
  assign o_sbit_cnt = '0;
  assign o_dbit_cnt = '0;
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl (AW=4, INTERVAL=4) with a behavioural
// Hamming(64,57) SECDED decoder and a 16-word memory model.
module tb_ecc_scrub_ctrl;
  import ecc_scrub_pkg::*;

  localparam int unsigned AW = 4;
`ifdef ECC_SCRUB_CNT_EN
  localparam logic [15:0] EXP_ONE = 16'd1;
`else
  localparam logic [15:0] EXP_ONE = 16'd0;
`endif

  logic          clk;
  logic          rst;
  logic          scrub_en;
  logic          usr_req;
  logic          usr_we;
  logic [AW-1:0] usr_addr;
  logic [15:0]   sbit_cnt;
  logic [15:0]   dbit_cnt;
  logic          dbit_irq;
  logic [AW-1:0] dbit_addr;
  logic          pass_done;

  ecc_scrub_ctrl_if #(.AW(AW)) bus_if ();

  ecc_scrub_ctrl #(.AW(AW), .INTERVAL(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_scrub_en  (scrub_en),
    .i_usr_req   (usr_req),
    .i_usr_we    (usr_we),
    .i_usr_addr  (usr_addr),
    .bus         (bus_if.master),
    .o_sbit_cnt  (sbit_cnt),
    .o_dbit_cnt  (dbit_cnt),
    .o_dbit_irq  (dbit_irq),
    .o_dbit_addr (dbit_addr),
    .o_pass_done (pass_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural SECDED ----------------
  function automatic logic [6:0] enc_par(input logic [56:0] d);
    logic [63:0] cw;
    logic [6:0]  p;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 64; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    p = '0;
    for (int b = 0; b < 6; b++)
      for (int pos = 1; pos < 64; pos++)
        if (((pos >> b) & 1) != 0) p[b] = p[b] ^ cw[pos];
    p[6] = (^d) ^ (^p[5:0]);
    return p;
  endfunction

  function automatic int pos2idx(input int pos);
    int k;
    k = 0;
    for (int j = 1; j < pos; j++)
      if ((j & (j - 1)) != 0) k++;
    return k;
  endfunction

  function automatic void decode(input logic [56:0] d, input logic [6:0] p,
                                 output logic [56:0] cd, output logic sb, output logic db);
    logic [6:0] pr;
    logic [5:0] syn;
    logic       ov;
    int         k;
    pr  = enc_par(d);
    syn = p[5:0] ^ pr[5:0];
    ov  = ^{p, d};
    cd  = d;
    sb  = 1'b0;
    db  = 1'b0;
    if (ov) begin
      sb = 1'b1;
      if (syn != 6'd0 && (syn & (syn - 6'd1)) != 6'd0) begin
        k     = pos2idx(int'(syn));
        cd[k] = ~d[k];
      end
    end else if (syn != 6'd0) begin
      db = 1'b1;
    end
  endfunction

  logic [56:0] m_cdata;
  logic        m_sbit;
  logic        m_dbit;

  always_comb begin
    m_cdata = bus_if.dec_data;
    m_sbit  = 1'b0;
    m_dbit  = 1'b0;
    if (!bus_if.dec_bypass) decode(bus_if.dec_data, bus_if.dec_parity, m_cdata, m_sbit, m_dbit);
  end

  assign bus_if.dec_cdata   = m_cdata;
  assign bus_if.dec_cparity = enc_par(m_cdata);
  assign bus_if.dec_sbit    = m_sbit;
  assign bus_if.dec_dbit    = m_dbit;

  // ---------------- memory model and monitor ----------------
  logic [63:0]   mem [16];
  logic [63:0]   r_rdata;
  logic [AW-1:0] rd_log [1024];
  int            n_reads, n_writes, n_pass, n_dirq, n_viol, reads_at_pass;
  logic [AW-1:0] last_wr_addr;
  logic [63:0]   last_wr_data;

  assign bus_if.mem_rdata = r_rdata;

  initial begin
    n_reads = 0; n_writes = 0; n_pass = 0; n_dirq = 0; n_viol = 0; reads_at_pass = 0;
    last_wr_addr = '0; last_wr_data = '0;
  end

  always @(posedge clk) begin
    if (bus_if.mem_re) begin
      r_rdata <= mem[bus_if.mem_addr];
      if (n_reads < 1024) rd_log[n_reads] = bus_if.mem_addr;
      n_reads = n_reads + 1;
    end
    if (bus_if.mem_we) begin
      n_writes     = n_writes + 1;
      last_wr_addr = bus_if.mem_addr;
      last_wr_data = bus_if.mem_wdata;
    end
    if (pass_done) begin
      n_pass        = n_pass + 1;
      reads_at_pass = n_reads;
    end
    if (dbit_irq) n_dirq = n_dirq + 1;
    if (usr_req && (bus_if.mem_re || bus_if.mem_we)) n_viol = n_viol + 1;
  end

  int n_chk;
  int n_ok;

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] good_word(input int i);
    logic [63:0] raw;
    logic [56:0] d;
    raw = 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h0000_0F0F_1357_9BDF);
    d   = raw[56:0];
    return {enc_par(d), d};
  endfunction

  task automatic load_mem();
    for (int i = 0; i < 16; i++) mem[i] = good_word(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; scrub_en = 1'b0; usr_req = 1'b0; usr_we = 1'b0; usr_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pass(input int base, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (n_pass > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_state(input scrub_state_e st, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (dut.r_state === st) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_chk++; if (dut.r_state !== IDLE) $display("FAIL reset_state got %0d want IDLE", dut.r_state); else n_ok++;
    n_chk++; if (bus_if.mem_re !== 1'b0) $display("FAIL reset_mem_re got %b want 0", bus_if.mem_re); else n_ok++;
    n_chk++; if (bus_if.mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", bus_if.mem_we); else n_ok++;
    n_chk++; if (bus_if.mem_addr !== 4'd0) $display("FAIL reset_mem_addr got %0d want 0", bus_if.mem_addr); else n_ok++;
    n_chk++; if (bus_if.mem_wdata !== 64'd0) $display("FAIL reset_mem_wdata got %h want 0", bus_if.mem_wdata); else n_ok++;
    n_chk++; if (bus_if.dec_bypass !== 1'b1) $display("FAIL reset_bypass got %b want 1", bus_if.dec_bypass); else n_ok++;
    n_chk++; if (sbit_cnt !== 16'd0) $display("FAIL reset_sbit_cnt got %0d want 0", sbit_cnt); else n_ok++;
    n_chk++; if (dbit_cnt !== 16'd0) $display("FAIL reset_dbit_cnt got %0d want 0", dbit_cnt); else n_ok++;
    n_chk++; if (dbit_addr !== 4'd0) $display("FAIL reset_dbit_addr got %0d want 0", dbit_addr); else n_ok++;
    n_chk++; if ({dbit_irq, pass_done} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {dbit_irq, pass_done}); else n_ok++;
  endtask

  task automatic test_clean_pass();
    int base_r, base_w, base_p;
    bit ok, ord_ok;
    do_reset();
    load_mem();
    base_r = n_reads; base_w = n_writes; base_p = n_pass;
    scrub_en = 1'b1;
    wait_pass(base_p, ok);
    scrub_en = 1'b0;
    n_chk++; if (ok !== 1'b1) $display("FAIL clean_pass_timeout got %b want 1", ok); else n_ok++;
    n_chk++; if (reads_at_pass - base_r !== 16) $display("FAIL clean_reads_at_pass got %0d want 16", reads_at_pass - base_r); else n_ok++;
    ord_ok = 1'b1;
    for (int i = 0; i < 16; i++) if (rd_log[base_r + i] !== 4'(i)) ord_ok = 1'b0;
    n_chk++; if (ord_ok !== 1'b1) $display("FAIL clean_read_order got %b want 1", ord_ok); else n_ok++;
    repeat (20) @(negedge clk);
    n_chk++; if (n_reads - base_r !== 16) $display("FAIL clean_reads got %0d want 16", n_reads - base_r); else n_ok++;
    n_chk++; if (n_writes - base_w !== 0) $display("FAIL clean_writes got %0d want 0", n_writes - base_w); else n_ok++;
    n_chk++; if (n_pass - base_p !== 1) $display("FAIL clean_pass_count got %0d want 1", n_pass - base_p); else n_ok++;
    n_chk++; if (sbit_cnt !== 16'd0) $display("FAIL clean_sbit_cnt got %0d want 0", sbit_cnt); else n_ok++;
  endtask

  task automatic test_sbit_fix();
    int base_w, base_p;
    bit ok;
    logic [63:0] good;
    do_reset();
    load_mem();
    good = mem[3];
    mem[3][10] = ~mem[3][10];
    base_w = n_writes; base_p = n_pass;
    scrub_en = 1'b1;
    wait_pass(base_p, ok);
    scrub_en = 1'b0;
    n_chk++; if (ok !== 1'b1) $display("FAIL sbit_pass_timeout got %b want 1", ok); else n_ok++;
    n_chk++; if (n_writes - base_w !== 1) $display("FAIL sbit_writes got %0d want 1", n_writes - base_w); else n_ok++;
    n_chk++; if (last_wr_addr !== 4'd3) $display("FAIL sbit_wr_addr got %0d want 3", last_wr_addr); else n_ok++;
    n_chk++; if (last_wr_data !== good) $display("FAIL sbit_wr_data got %h want %h", last_wr_data, good); else n_ok++;
    n_chk++; if (sbit_cnt !== EXP_ONE) $display("FAIL sbit_cnt got %0d want %0d", sbit_cnt, EXP_ONE); else n_ok++;
    n_chk++; if (dbit_cnt !== 16'd0) $display("FAIL sbit_dbit_cnt got %0d want 0", dbit_cnt); else n_ok++;
  endtask

  task automatic test_dbit_report();
    int base_w, base_p, base_i;
    bit ok;
    do_reset();
    load_mem();
    mem[5][0] = ~mem[5][0];
    mem[5][1] = ~mem[5][1];
    base_w = n_writes; base_p = n_pass; base_i = n_dirq;
    scrub_en = 1'b1;
    wait_pass(base_p, ok);
    scrub_en = 1'b0;
    n_chk++; if (ok !== 1'b1) $display("FAIL dbit_pass_timeout got %b want 1", ok); else n_ok++;
    n_chk++; if (n_writes - base_w !== 0) $display("FAIL dbit_writes got %0d want 0", n_writes - base_w); else n_ok++;
    n_chk++; if (n_dirq - base_i !== 1) $display("FAIL dbit_irq_cycles got %0d want 1", n_dirq - base_i); else n_ok++;
    n_chk++; if (dbit_addr !== 4'd5) $display("FAIL dbit_addr got %0d want 5", dbit_addr); else n_ok++;
    n_chk++; if (dbit_cnt !== EXP_ONE) $display("FAIL dbit_cnt got %0d want %0d", dbit_cnt, EXP_ONE); else n_ok++;
    n_chk++; if (sbit_cnt !== 16'd0) $display("FAIL dbit_sbit_cnt got %0d want 0", sbit_cnt); else n_ok++;
  endtask

  task automatic test_rd_wait();
    int base_r, base_v, bad;
    do_reset();
    load_mem();
    base_r = n_reads; base_v = n_viol;
    scrub_en = 1'b1;
    repeat (3) @(negedge clk);
    usr_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dut.r_state !== RD || bus_if.mem_re !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL rdwait_held got %0d bad cycles want 0", bad); else n_ok++;
    @(negedge clk);
    usr_req = 1'b0;
    #1;
    n_chk++; if (bus_if.mem_re !== 1'b1) $display("FAIL rdwait_release_re got %b want 1", bus_if.mem_re); else n_ok++;
    n_chk++; if (bus_if.mem_addr !== 4'd0) $display("FAIL rdwait_release_addr got %0d want 0", bus_if.mem_addr); else n_ok++;
    scrub_en = 1'b0;
    repeat (10) @(negedge clk);
    n_chk++; if (n_reads - base_r !== 1) $display("FAIL rdwait_reads got %0d want 1", n_reads - base_r); else n_ok++;
    n_chk++; if (dut.r_state !== IDLE || bus_if.mem_addr !== 4'd1) $display("FAIL rdwait_hold_idle got st=%0d addr=%0d want IDLE/1", dut.r_state, bus_if.mem_addr); else n_ok++;
    n_chk++; if (n_viol - base_v !== 0) $display("FAIL rdwait_priority got %0d want 0", n_viol - base_v); else n_ok++;
  endtask

  task automatic test_clash_cancel();
    int base_r, base_w;
    bit ok, ok2;
    do_reset();
    load_mem();
    mem[3][10] = ~mem[3][10];
    base_r = n_reads; base_w = n_writes;
    scrub_en = 1'b1;
    wait_state(ENC, ok);
    n_chk++; if (ok !== 1'b1 || bus_if.mem_addr !== 4'd3) $display("FAIL clash_reach_enc got ok=%b addr=%0d want 1/3", ok, bus_if.mem_addr); else n_ok++;
    usr_req = 1'b1; usr_we = 1'b1; usr_addr = 4'd3;
    mem[3] = good_word(3);
    @(negedge clk);
    usr_req = 1'b0; usr_we = 1'b0; usr_addr = '0;
    n_chk++; if (dut.r_state !== NEXT) $display("FAIL clash_to_next got %0d want NEXT", dut.r_state); else n_ok++;
    ok2 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n_reads - base_r >= 5) begin ok2 = 1'b1; break; end
    end
    scrub_en = 1'b0;
    n_chk++; if (ok2 !== 1'b1) $display("FAIL clash_next_read_timeout got %b want 1", ok2); else n_ok++;
    n_chk++; if (rd_log[base_r + 4] !== 4'd4) $display("FAIL clash_next_addr got %0d want 4", rd_log[base_r + 4]); else n_ok++;
    n_chk++; if (n_writes - base_w !== 0) $display("FAIL clash_writes got %0d want 0", n_writes - base_w); else n_ok++;
    n_chk++; if (sbit_cnt !== EXP_ONE) $display("FAIL clash_sbit_cnt got %0d want %0d", sbit_cnt, EXP_ONE); else n_ok++;
  endtask

  task automatic test_rst_in_wr();
    int base_w;
    bit ok;
    do_reset();
    load_mem();
    mem[3][10] = ~mem[3][10];
    base_w = n_writes;
    scrub_en = 1'b1;
    wait_state(ENC, ok);
    usr_req = 1'b1;
    @(negedge clk);
    n_chk++; if (ok !== 1'b1 || dut.r_state !== WR) $display("FAIL rstwr_reach_wr got ok=%b st=%0d want 1/WR", ok, dut.r_state); else n_ok++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (dut.r_state !== IDLE) $display("FAIL rstwr_state got %0d want IDLE", dut.r_state); else n_ok++;
    n_chk++; if (bus_if.mem_addr !== 4'd0) $display("FAIL rstwr_scrub_addr got %0d want 0", bus_if.mem_addr); else n_ok++;
    n_chk++; if ({sbit_cnt, dbit_cnt} !== 32'd0) $display("FAIL rstwr_counters got %0d/%0d want 0/0", sbit_cnt, dbit_cnt); else n_ok++;
    rst = 1'b0; usr_req = 1'b0; scrub_en = 1'b0;
    repeat (10) @(negedge clk);
    n_chk++; if (n_writes - base_w !== 0) $display("FAIL rstwr_writes got %0d want 0", n_writes - base_w); else n_ok++;
    n_chk++; if (bus_if.mem_wdata !== 64'd0) $display("FAIL rstwr_wdata got %h want 0", bus_if.mem_wdata); else n_ok++;
  endtask

  initial begin
    n_chk = 0; n_ok = 0;
    rst = 1'b1; scrub_en = 1'b0; usr_req = 1'b0; usr_we = 1'b0; usr_addr = '0;
    test_reset();
    test_clean_pass();
    test_sbit_fix();
    test_dbit_report();
    test_rd_wait();
    test_clash_cancel();
    test_rst_in_wr();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
